// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
package spi_sched_pkg;

    localparam int unsigned LEN_W = 2;
    localparam int unsigned IDX_W = 2;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_SETUP = 3'd2,
        ST_BYTE  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_END   = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    typedef struct packed {
        logic [7:0]       cmd;
        logic [23:0]      wdata;
        logic [LEN_W-1:0] len;
        logic             read;
    } txn_t;

    // Byte to shift out at a given index: command first, then write data MSB-first or dummy on reads.
    function automatic logic [7:0] tx_byte_sel(input txn_t txn, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = txn.cmd;
            2'd1:    b = txn.wdata[23:16];
            2'd2:    b = txn.wdata[15:8];
            default: b = txn.wdata[7:0];
        endcase
        if (idx != '0 && txn.read) begin
            b = DUMMY_BYTE;
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant only advances when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant_c,
    output logic       grant_idx_c
);

    logic last_grant_q;
    logic last_grant_d;
    logic preferred;

    // The requester that did not win last time has priority.
    always_comb begin
        preferred   = ~last_grant_q;
        grant_idx_c = req[preferred] ? preferred : last_grant_q;
        grant_c     = (|req) ? (2'b01 << grant_idx_c) : 2'b00;
        last_grant_d = last_grant_q;
        if (en && (|req)) begin
            last_grant_d = grant_idx_c;
        end
    end

    // Reset to 1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Arbitrates two requesters onto one SPI byte engine, frames chip select and
// sequences command plus 0-3 data bytes, returning read data or a timeout flag.
module spi_txn_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_cmd,
    input  logic [47:0] req_wdata,
    input  logic [3:0]  req_len,
    input  logic [1:0]  req_read,
    output logic [1:0]  resp_valid,
    output logic [23:0] resp_data,
    output logic        resp_err,
    output logic        spi_start,
    output logic [7:0]  spi_tx_byte,
    output logic        spi_rx_en,
    output logic        cs,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx_byte
);

    localparam int unsigned TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_W = (TO_W > 4) ? TO_W : 4;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    txn_t              txn_q, txn_d;
    txn_t              sel_txn;
    logic [23:0]       resp_data_q, resp_data_d;

    logic [1:0]        req_ready_q, req_ready_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              spi_start_q, spi_start_d;
    logic [7:0]        spi_tx_byte_q, spi_tx_byte_d;
    logic              spi_rx_en_q, spi_rx_en_d;
    logic              cs_q, cs_d;

    logic              arb_en;
    logic [1:0]        grant_c;
    logic              grant_idx_c;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .en          (arb_en),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    // Request fields of whichever requester the arbiter is granting.
    always_comb begin
        sel_txn.cmd   = grant_idx_c ? req_cmd[15:8]    : req_cmd[7:0];
        sel_txn.wdata = grant_idx_c ? req_wdata[47:24] : req_wdata[23:0];
        sel_txn.len   = grant_idx_c ? req_len[3:2]     : req_len[1:0];
        sel_txn.read  = grant_idx_c ? req_read[1]      : req_read[0];
    end

    // Next-state and transaction bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        owner_d     = owner_q;
        err_d       = err_q;
        txn_d       = txn_q;
        resp_data_d = resp_data_q;
        arb_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    arb_en      = 1'b1;
                    owner_d     = grant_idx_c;
                    txn_d       = sel_txn;
                    err_d       = 1'b0;
                    resp_data_d = '0;
                    state_d     = ST_ARB;
                end
            end
            ST_ARB: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    state_d = ST_BYTE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BYTE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done landing on the terminal count still counts as a good byte.
                if (spi_done) begin
                    if (idx_q != '0 && txn_q.read) begin
                        resp_data_d = {resp_data_q[15:0], spi_rx_byte};
                    end
                    if (idx_q == txn_q.len) begin
                        state_d = ST_END;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_BYTE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_END;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_END: begin
                cnt_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values decoded from the upcoming state so the registers line up with it.
    always_comb begin
        req_ready_d   = arb_en ? grant_c : 2'b00;
        cs_d          = !((state_d == ST_SETUP) || (state_d == ST_BYTE) || (state_d == ST_WAIT));
        spi_start_d   = (state_d == ST_BYTE);
        spi_tx_byte_d = spi_tx_byte_q;
        spi_rx_en_d   = 1'b0;
        resp_valid_d  = 2'b00;
        resp_err_d    = 1'b0;

        if (state_d == ST_BYTE) begin
            spi_tx_byte_d = tx_byte_sel(txn_q, idx_d);
            spi_rx_en_d   = (idx_d != '0) && txn_q.read;
        end else if (state_d == ST_WAIT) begin
            spi_rx_en_d   = spi_rx_en_q;
        end

        if (state_d == ST_END) begin
            resp_valid_d = owner_q ? 2'b10 : 2'b01;
            resp_err_d   = err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            owner_q       <= 1'b0;
            err_q         <= 1'b0;
            txn_q         <= '0;
            resp_data_q   <= '0;
            req_ready_q   <= 2'b00;
            resp_valid_q  <= 2'b00;
            resp_err_q    <= 1'b0;
            spi_start_q   <= 1'b0;
            spi_tx_byte_q <= 8'h00;
            spi_rx_en_q   <= 1'b0;
            cs_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            owner_q       <= owner_d;
            err_q         <= err_d;
            txn_q         <= txn_d;
            resp_data_q   <= resp_data_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            spi_start_q   <= spi_start_d;
            spi_tx_byte_q <= spi_tx_byte_d;
            spi_rx_en_q   <= spi_rx_en_d;
            cs_q          <= cs_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign spi_start   = spi_start_q;
    assign spi_tx_byte = spi_tx_byte_q;
    assign spi_rx_en   = spi_rx_en_q;
    assign cs          = cs_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Self-checking bench for spi_txn_scheduler: behavioural SPI engine, event logs
// and per-scenario checks against transaction-level expectations.
module tb_spi_txn_scheduler;

    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_GAP   = 4;
    localparam int unsigned TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_cmd;
    logic [47:0] req_wdata;
    logic [3:0]  req_len;
    logic [1:0]  req_read;
    logic [1:0]  resp_valid;
    logic [23:0] resp_data;
    logic        resp_err;
    logic        spi_start;
    logic [7:0]  spi_tx_byte;
    logic        spi_rx_en;
    logic        cs;
    logic        spi_done;
    logic [7:0]  spi_rx_byte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_txn_scheduler #(
        .CS_SETUP (CS_SETUP),
        .CS_GAP   (CS_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_wdata   (req_wdata),
        .req_len     (req_len),
        .req_read    (req_read),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .spi_start   (spi_start),
        .spi_tx_byte (spi_tx_byte),
        .spi_rx_en   (spi_rx_en),
        .cs          (cs),
        .spi_done    (spi_done),
        .spi_rx_byte (spi_rx_byte)
    );

    // Event logs (written only by the monitor / engine processes)
    int         cyc = 0;
    logic [7:0] tx_log[$];
    logic       rxen_log[$];
    int         start_cyc[$];
    logic [1:0] rdy_vec[$];
    int         rdy_cyc[$];
    logic [1:0] rsp_vec[$];
    logic [23:0] rsp_data[$];
    logic       rsp_err[$];
    logic       rsp_cs[$];
    int         rsp_cyc[$];
    int         gap_len[$];
    int         done_cyc[$];
    logic [7:0] rx_sent[$];

    // Engine controls (written only by the test tasks)
    int         eng_lat = 1;
    bit         use_fixed = 1'b0;
    int         fixed_base = 0;
    logic [7:0] fixed_b [4];
    int         stray_req = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural byte engine: done eng_lat cycles after start; eng_lat==0 never answers.
    initial begin : engine
        int pend;
        int stray_seen;
        logic [7:0] b;
        pend = 0;
        stray_seen = 0;
        spi_done = 1'b0;
        spi_rx_byte = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    b = use_fixed ? fixed_b[(rx_sent.size() - fixed_base) % 4] : 8'($urandom);
                    spi_rx_byte = b;
                    spi_done = 1'b1;
                    rx_sent.push_back(b);
                    done_cyc.push_back(cyc);
                end
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                spi_done = 1'b1;
                spi_rx_byte = 8'hEE;
            end
            if (spi_start && eng_lat > 0) pend = eng_lat;
        end
    end

    initial begin : monitor
        logic cs_prev;
        int cs_rise;
        cs_prev = 1'b1;
        cs_rise = 0;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                tx_log.push_back(spi_tx_byte);
                rxen_log.push_back(spi_rx_en);
                start_cyc.push_back(cyc);
            end
            if (|req_ready) begin
                rdy_vec.push_back(req_ready);
                rdy_cyc.push_back(cyc);
            end
            if (|resp_valid) begin
                rsp_vec.push_back(resp_valid);
                rsp_data.push_back(resp_data);
                rsp_err.push_back(resp_err);
                rsp_cs.push_back(cs);
                rsp_cyc.push_back(cyc);
            end
            if (cs === 1'b1 && cs_prev === 1'b0) cs_rise = cyc;
            if (cs === 1'b0 && cs_prev === 1'b1) gap_len.push_back(cyc - cs_rise);
            cs_prev = cs;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one request and waits for its grant and its response; no checking here.
    task automatic run_txn(input int r, input logic [7:0] c, input logic [1:0] l, input logic rd,
                           input logic [23:0] wd, input int lat,
                           output int b_tx, output int b_rdy, output int b_rsp, output int b_rx,
                           output bit ok);
        b_tx  = tx_log.size();
        b_rdy = rdy_vec.size();
        b_rsp = rsp_vec.size();
        b_rx  = rx_sent.size();
        ok    = 1'b0;
        eng_lat = lat;
        if (r == 0) begin
            req_cmd[7:0] = c; req_wdata[23:0] = wd; req_len[1:0] = l; req_read[0] = rd;
        end else begin
            req_cmd[15:8] = c; req_wdata[47:24] = wd; req_len[3:2] = l; req_read[1] = rd;
        end
        req_valid[r] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (rdy_vec.size() > b_rdy) break;
        end
        req_valid[r] = 1'b0;
        if (rdy_vec.size() > b_rdy) begin
            for (int n = 0; n < 5000; n++) begin
                if (rsp_vec.size() > b_rsp) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs got %b exp 1", cs); end
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", spi_start); end
        checks++; if (spi_rx_en !== 1'b0) begin errors++; $display("FAIL rst_rxen got %b exp 0", spi_rx_en); end
        checks++; if (spi_tx_byte !== 8'h00) begin errors++; $display("FAIL rst_tx got %h exp 00", spi_tx_byte); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp got %b exp 00", resp_valid); end
        checks++; if (resp_data !== 24'h0) begin errors++; $display("FAIL rst_data got %h exp 0", resp_data); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", resp_err); end
    endtask

    task automatic test_write();
        int b_tx, b_rdy, b_rsp, b_rx;
        bit ok;
        run_txn(0, 8'h2D, 2'd1, 1'b0, 24'h080000, 3, b_tx, b_rdy, b_rsp, b_rx, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_done got %b exp 1", ok); end
        if (ok) begin
            checks++; if (rdy_vec[b_rdy] !== 2'b01) begin errors++; $display("FAIL wr_ready got %b exp 01", rdy_vec[b_rdy]); end
            checks++; if (tx_log.size() - b_tx !== 2) begin errors++; $display("FAIL wr_nbytes got %0d exp 2", tx_log.size() - b_tx); end
            checks++; if (tx_log[b_tx] !== 8'h2D) begin errors++; $display("FAIL wr_tx0 got %h exp 2d", tx_log[b_tx]); end
            checks++; if (tx_log[b_tx+1] !== 8'h08) begin errors++; $display("FAIL wr_tx1 got %h exp 08", tx_log[b_tx+1]); end
            checks++; if ((rxen_log[b_tx] | rxen_log[b_tx+1]) !== 1'b0) begin errors++; $display("FAIL wr_rxen got %b%b exp 00", rxen_log[b_tx], rxen_log[b_tx+1]); end
            checks++; if (start_cyc[b_tx] !== rdy_cyc[b_rdy] + 1 + int'(CS_SETUP)) begin errors++; $display("FAIL wr_start_lat got %0d exp %0d", start_cyc[b_tx] - rdy_cyc[b_rdy], 1 + CS_SETUP); end
            checks++; if (rsp_vec[b_rsp] !== 2'b01) begin errors++; $display("FAIL wr_resp got %b exp 01", rsp_vec[b_rsp]); end
            checks++; if (rsp_cyc[b_rsp] !== done_cyc[b_rx+1] + 1) begin errors++; $display("FAIL wr_resp_lat got %0d exp %0d", rsp_cyc[b_rsp], done_cyc[b_rx+1] + 1); end
            checks++; if (rsp_data[b_rsp] !== 24'h0) begin errors++; $display("FAIL wr_data got %h exp 0", rsp_data[b_rsp]); end
            checks++; if (rsp_err[b_rsp] !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", rsp_err[b_rsp]); end
            checks++; if (rsp_cs[b_rsp] !== 1'b1) begin errors++; $display("FAIL wr_cs_end got %b exp 1", rsp_cs[b_rsp]); end
        end
    endtask

    task automatic test_read();
        int b_tx, b_rdy, b_rsp, b_rx;
        bit ok;
        fixed_b[0] = 8'h00; fixed_b[1] = 8'hA1; fixed_b[2] = 8'hB2; fixed_b[3] = 8'hC3;
        fixed_base = rx_sent.size();
        use_fixed = 1'b1;
        run_txn(1, 8'hF2, 2'd3, 1'b1, 24'($urandom), 2, b_tx, b_rdy, b_rsp, b_rx, ok);
        use_fixed = 1'b0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_done got %b exp 1", ok); end
        if (ok) begin
            checks++; if (rdy_vec[b_rdy] !== 2'b10) begin errors++; $display("FAIL rd_ready got %b exp 10", rdy_vec[b_rdy]); end
            checks++; if (tx_log.size() - b_tx !== 4) begin errors++; $display("FAIL rd_nbytes got %0d exp 4", tx_log.size() - b_tx); end
            for (int k = 0; k < 4; k++) begin
                checks++; if (tx_log[b_tx+k] !== ((k == 0) ? 8'hF2 : 8'h00)) begin errors++; $display("FAIL rd_tx%0d got %h", k, tx_log[b_tx+k]); end
                checks++; if (rxen_log[b_tx+k] !== (k != 0)) begin errors++; $display("FAIL rd_rxen%0d got %b exp %b", k, rxen_log[b_tx+k], k != 0); end
            end
            checks++; if (rsp_vec[b_rsp] !== 2'b10) begin errors++; $display("FAIL rd_resp got %b exp 10", rsp_vec[b_rsp]); end
            checks++; if (rsp_data[b_rsp] !== 24'hA1B2C3) begin errors++; $display("FAIL rd_data got %h exp a1b2c3", rsp_data[b_rsp]); end
            checks++; if (rsp_err[b_rsp] !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", rsp_err[b_rsp]); end
        end
    endtask

    task automatic test_random();
        int b_tx, b_rdy, b_rsp, b_rx;
        bit ok;
        int r, lat, l;
        logic [7:0] c;
        logic rd;
        logic [23:0] wd, acc;
        logic [7:0] exp_tx;
        for (int t = 0; t < 24; t++) begin
            r = int'($urandom_range(0, 1));
            l = int'($urandom_range(0, 3));
            c = 8'($urandom);
            rd = 1'($urandom);
            wd = 24'($urandom);
            lat = int'($urandom_range(1, 5));
            run_txn(r, c, 2'(l), rd, wd, lat, b_tx, b_rdy, b_rsp, b_rx, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_done got %b exp 1", t, ok); end
            if (ok) begin
                checks++; if (rdy_vec[b_rdy] !== ((r == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd%0d_ready got %b req %0d", t, rdy_vec[b_rdy], r); end
                checks++; if (tx_log.size() - b_tx !== l + 1) begin errors++; $display("FAIL rnd%0d_nbytes got %0d exp %0d", t, tx_log.size() - b_tx, l + 1); end
                for (int k = 0; k <= l; k++) begin
                    exp_tx = (k == 0) ? c : (rd ? 8'h00 : 8'(wd >> (8 * (3 - k))));
                    checks++; if (tx_log[b_tx+k] !== exp_tx) begin errors++; $display("FAIL rnd%0d_tx%0d got %h exp %h", t, k, tx_log[b_tx+k], exp_tx); end
                    checks++; if (rxen_log[b_tx+k] !== (k > 0 && rd)) begin errors++; $display("FAIL rnd%0d_rxen%0d got %b", t, k, rxen_log[b_tx+k]); end
                end
                acc = 24'h0;
                if (rd) for (int k = 1; k <= l; k++) acc = {acc[15:0], rx_sent[b_rx+k]};
                checks++; if (rsp_data[b_rsp] !== acc) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", t, rsp_data[b_rsp], acc); end
                checks++; if (rsp_err[b_rsp] !== 1'b0) begin errors++; $display("FAIL rnd%0d_err got %b exp 0", t, rsp_err[b_rsp]); end
                checks++; if (rsp_vec[b_rsp] !== rdy_vec[b_rdy]) begin errors++; $display("FAIL rnd%0d_owner got %b exp %b", t, rsp_vec[b_rsp], rdy_vec[b_rdy]); end
                checks++; if (rsp_cyc[b_rsp] !== done_cyc[b_rx+l] + 1) begin errors++; $display("FAIL rnd%0d_resp_lat got %0d exp %0d", t, rsp_cyc[b_rsp], done_cyc[b_rx+l] + 1); end
                checks++; if (start_cyc[b_tx] !== rdy_cyc[b_rdy] + 1 + int'(CS_SETUP)) begin errors++; $display("FAIL rnd%0d_start_lat got %0d", t, start_cyc[b_tx] - rdy_cyc[b_rdy]); end
            end
        end
    endtask

    task automatic test_timeout();
        int b_tx, b_rdy, b_rsp, b_rx;
        bit ok;
        logic [23:0] acc;
        run_txn(0, 8'($urandom), 2'd1, 1'b0, 24'($urandom), 0, b_tx, b_rdy, b_rsp, b_rx, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_done got %b exp 1", ok); end
        if (ok) begin
            checks++; if (tx_log.size() - b_tx !== 1) begin errors++; $display("FAIL to_nbytes got %0d exp 1", tx_log.size() - b_tx); end
            checks++; if (rsp_vec[b_rsp] !== 2'b01) begin errors++; $display("FAIL to_resp got %b exp 01", rsp_vec[b_rsp]); end
            checks++; if (rsp_err[b_rsp] !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", rsp_err[b_rsp]); end
            checks++; if (rsp_cs[b_rsp] !== 1'b1) begin errors++; $display("FAIL to_cs got %b exp 1", rsp_cs[b_rsp]); end
            checks++; if (rsp_cyc[b_rsp] !== start_cyc[b_tx] + 1 + int'(TIMEOUT)) begin errors++; $display("FAIL to_lat got %0d exp %0d", rsp_cyc[b_rsp] - start_cyc[b_tx], 1 + TIMEOUT); end
        end
        run_txn(1, 8'($urandom), 2'd2, 1'b1, 24'($urandom), 2, b_tx, b_rdy, b_rsp, b_rx, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_next_done got %b exp 1", ok); end
        if (ok) begin
            acc = {8'h00, rx_sent[b_rx+1], rx_sent[b_rx+2]};
            checks++; if (rsp_err[b_rsp] !== 1'b0) begin errors++; $display("FAIL to_next_err got %b exp 0", rsp_err[b_rsp]); end
            checks++; if (rsp_data[b_rsp] !== acc) begin errors++; $display("FAIL to_next_data got %h exp %h", rsp_data[b_rsp], acc); end
        end
    endtask

    task automatic test_done_at_terminal();
        int b_tx, b_rdy, b_rsp, b_rx;
        bit ok;
        // Done on the last WAIT cycle is accepted.
        run_txn(0, 8'($urandom), 2'd1, 1'b1, 24'($urandom), int'(TIMEOUT), b_tx, b_rdy, b_rsp, b_rx, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL term_done got %b exp 1", ok); end
        if (ok) begin
            checks++; if (tx_log.size() - b_tx !== 2) begin errors++; $display("FAIL term_nbytes got %0d exp 2", tx_log.size() - b_tx); end
            checks++; if (rsp_err[b_rsp] !== 1'b0) begin errors++; $display("FAIL term_err got %b exp 0", rsp_err[b_rsp]); end
            checks++; if (rsp_data[b_rsp] !== {16'h0, rx_sent[b_rx+1]}) begin errors++; $display("FAIL term_data got %h exp %h", rsp_data[b_rsp], {16'h0, rx_sent[b_rx+1]}); end
        end
        // One cycle later is too late.
        run_txn(1, 8'($urandom), 2'd1, 1'b1, 24'($urandom), int'(TIMEOUT) + 1, b_tx, b_rdy, b_rsp, b_rx, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL late_done got %b exp 1", ok); end
        if (ok) begin
            checks++; if (tx_log.size() - b_tx !== 1) begin errors++; $display("FAIL late_nbytes got %0d exp 1", tx_log.size() - b_tx); end
            checks++; if (rsp_err[b_rsp] !== 1'b1) begin errors++; $display("FAIL late_err got %b exp 1", rsp_err[b_rsp]); end
            checks++; if (rsp_cyc[b_rsp] !== start_cyc[b_tx] + 1 + int'(TIMEOUT)) begin errors++; $display("FAIL late_lat got %0d exp %0d", rsp_cyc[b_rsp] - start_cyc[b_tx], 1 + TIMEOUT); end
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int b_tx, b_rdy, b_rsp;
        bit seen;
        b_tx = tx_log.size();
        b_rdy = rdy_vec.size();
        b_rsp = rsp_vec.size();
        eng_lat = 0;
        req_cmd[7:0] = 8'($urandom); req_len[1:0] = 2'd2; req_read[0] = 1'b1;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (rdy_vec.size() > b_rdy) break;
        end
        req_valid[0] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (tx_log.size() > b_tx) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rm_started got %b exp 1", seen); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rm_cs got %b exp 1", cs); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rm_resp got %b exp 00", resp_valid); end
        stray_req++;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (rsp_vec.size() !== b_rsp) begin errors++; $display("FAIL rm_no_resp got %0d exp %0d", rsp_vec.size(), b_rsp); end
        checks++; if (tx_log.size() !== b_tx + 1) begin errors++; $display("FAIL rm_no_start got %0d exp %0d", tx_log.size(), b_tx + 1); end
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rm_cs_idle got %b exp 1", cs); end
        eng_lat = 1;
        req_len = 4'h0;
        req_valid = 2'b11;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (rdy_vec.size() > b_rdy + 1) break;
        end
        req_valid = 2'b00;
        checks++; if (rdy_vec.size() !== b_rdy + 2) begin errors++; $display("FAIL rm_regrant got %0d grants exp %0d", rdy_vec.size() - b_rdy, 2); end
        else begin
            checks++; if (rdy_vec[b_rdy+1] !== 2'b01) begin errors++; $display("FAIL rm_first_owner got %b exp 01", rdy_vec[b_rdy+1]); end
        end
        for (int n = 0; n < 100; n++) begin
            if (rsp_vec.size() > b_rsp) break;
            @(posedge clk);
            #1;
        end
        checks++; if (rsp_vec.size() !== b_rsp + 1) begin errors++; $display("FAIL rm_resp_after got %0d exp %0d", rsp_vec.size() - b_rsp, 1); end
    endtask

    task automatic test_back_to_back();
        int b_rdy, b_rsp, b_gap;
        logic [1:0] exp_v;
        do_reset();
        b_rdy = rdy_vec.size();
        b_rsp = rsp_vec.size();
        b_gap = gap_len.size();
        eng_lat = 1;
        req_cmd = 16'($urandom);
        req_len = 4'h0;
        req_read = 2'($urandom);
        req_valid = 2'b11;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (rdy_vec.size() >= b_rdy + 6) break;
        end
        req_valid = 2'b00;
        for (int n = 0; n < 100; n++) begin
            if (rsp_vec.size() >= b_rsp + 6) break;
            @(posedge clk);
            #1;
        end
        checks++; if (rdy_vec.size() !== b_rdy + 6) begin errors++; $display("FAIL b2b_grants got %0d exp 6", rdy_vec.size() - b_rdy); end
        checks++; if (rsp_vec.size() !== b_rsp + 6) begin errors++; $display("FAIL b2b_resps got %0d exp 6", rsp_vec.size() - b_rsp); end
        if (rdy_vec.size() == b_rdy + 6 && rsp_vec.size() == b_rsp + 6) begin
            for (int i = 0; i < 6; i++) begin
                exp_v = (i % 2 == 1) ? 2'b10 : 2'b01;
                checks++; if (rdy_vec[b_rdy+i] !== exp_v) begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", i, rdy_vec[b_rdy+i], exp_v); end
                checks++; if (rsp_vec[b_rsp+i] !== exp_v) begin errors++; $display("FAIL b2b_resp%0d got %b exp %b", i, rsp_vec[b_rsp+i], exp_v); end
                checks++; if (rsp_data[b_rsp+i] !== 24'h0) begin errors++; $display("FAIL b2b_data%0d got %h exp 0", i, rsp_data[b_rsp+i]); end
                if (i > 0) begin
                    checks++; if (rdy_cyc[b_rdy+i] - rsp_cyc[b_rsp+i-1] < 1 + int'(CS_GAP)) begin errors++; $display("FAIL b2b_arb_gap%0d got %0d min %0d", i, rdy_cyc[b_rdy+i] - rsp_cyc[b_rsp+i-1], 1 + CS_GAP); end
                end
            end
        end
        checks++; if (gap_len.size() < b_gap + 6) begin errors++; $display("FAIL b2b_frames got %0d exp 6", gap_len.size() - b_gap); end
        else begin
            for (int i = 1; i < 6; i++) begin
                checks++; if (gap_len[b_gap+i] < int'(CS_GAP)) begin errors++; $display("FAIL b2b_cs_gap%0d got %0d min %0d", i, gap_len[b_gap+i], CS_GAP); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_cmd = 16'h0;
        req_wdata = 48'h0;
        req_len = 4'h0;
        req_read = 2'b00;
        test_reset();
        test_write();
        test_read();
        test_random();
        test_timeout();
        test_done_at_terminal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
